// File: rtl/alu_sequencer.sv
// Issues decoded instructions to an external combinational ALU, writes back, returns the result.
// Latency: operands registered on accept (T0), writeback and res_valid at T0+1, earliest handshake T0+2.
// Backpressure: result held stable while res_ready is low; instr_ready only in IDLE.
module alu_sequencer #(
    parameter int REG_ADDR_W = 2,
    parameter int RETIRE_W   = 8,
    parameter int INSTR_W    = 3 + 2*REG_ADDR_W + 1 + 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instr,
    output logic [7:0]            alu_ina,
    output logic [7:0]            alu_inb,
    output logic [2:0]            alu_opcode,
    input  logic [7:0]            alu_out,
    input  logic                  alu_cout,
    input  logic                  alu_carry_flag,
    input  logic                  alu_zero_flag,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [7:0]            res_data,
    output logic [2:0]            status,
    output logic [RETIRE_W-1:0]   retired,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [7:0]            dbg_data
);

    localparam int NREGS = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t                state;
    logic [7:0]            regs [NREGS];
    logic [REG_ADDR_W-1:0] rd_q;

    logic [2:0]            f_op;
    logic [REG_ADDR_W-1:0] f_rd;
    logic [REG_ADDR_W-1:0] f_ra;
    logic                  f_sel;
    logic [7:0]            f_imm;

    assign f_op  = instr[INSTR_W-1 -: 3];
    assign f_rd  = instr[8+2*REG_ADDR_W -: REG_ADDR_W];
    assign f_ra  = instr[8+REG_ADDR_W -: REG_ADDR_W];
    assign f_sel = instr[8];
    assign f_imm = instr[7:0];

    assign instr_ready = (state == IDLE);
    assign dbg_data    = regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 8'h00;
            end
            rd_q       <= '0;
            alu_ina    <= 8'h00;
            alu_inb    <= 8'h00;
            alu_opcode <= 3'b000;
            res_valid  <= 1'b0;
            res_data   <= 8'h00;
            status     <= 3'b000;
            retired    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        alu_opcode <= f_op;
                        alu_ina    <= regs[f_ra];
                        // Register mode reuses the low imm bits as the second source address.
                        alu_inb    <= f_sel ? f_imm : regs[f_imm[REG_ADDR_W-1:0]];
                        rd_q       <= f_rd;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    regs[rd_q] <= alu_out;
                    res_data   <= alu_out;
                    status     <= {alu_cout, alu_carry_flag, alu_zero_flag};
                    res_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        retired   <= retired + RETIRE_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction-issuing front end for the team's 8-bit `alu` block. It accepts encoded instruction words over a valid/ready handshake and decodes them against a small internal register file. It drives registered operands and opcode into the ALU, captures the ALU result and flags, writes the result back to the register file, and returns the result over a second valid/ready handshake. It sits between the instruction source (testbench or a future fetch unit) and a combinational `alu` instance.

## Interface
- `REG_ADDR_W`, default 2: register address width; the register file has 2^REG_ADDR_W entries of 8 bits.
- `RETIRE_W`, default 8: width of the retired-instruction counter.
- `INSTR_W`, default 3+2*REG_ADDR_W+1+8 (16): derived instruction width; not overridden.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `instr_valid`  in  1: instruction word present.
- `instr_ready`  out  1: sequencer can accept an instruction.
- `instr`  in  INSTR_W: bit fields are `op`[15:13], `rd`[12:11], `ra`[10:9], `imm_sel`[8], `imm`[7:0] (fields shift with REG_ADDR_W).
- `alu_ina`, `alu_inb`  out  8: registered operands to the ALU.
- `alu_opcode`  out  3: registered opcode to the ALU.
- `alu_out`  in  8: ALU result.
- `alu_cout`, `alu_carry_flag`, `alu_zero_flag`  in  1 each: ALU flags.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: consumer accepts the result.
- `res_data`  out  8: captured result.
- `status`  out  3: {cout, carry_flag, zero_flag} captured with the last result.
- `retired`  out  RETIRE_W: count of completed response handshakes.
- `dbg_addr`  in  REG_ADDR_W: debug read address.
- `dbg_data`  out  8: combinational read of `regs[dbg_addr]`.

## Operation
- The FSM has three states: IDLE, EXEC and RESP. `instr_ready` = (state == IDLE).
- IDLE, on `instr_valid`:
  - Load `alu_opcode` <= `op`.
  - Load `alu_ina` <= `regs[ra]`.
  - Load `alu_inb` <= `imm_sel` ? `imm` : `regs[imm[REG_ADDR_W-1:0]]`.
  - Latch `rd`, then go to EXEC.
- EXEC lasts exactly one cycle. At its end:
  - `regs[rd]` <= `alu_out`.
  - `res_data` <= `alu_out`.
  - `status` <= {`alu_cout`, `alu_carry_flag`, `alu_zero_flag`}.
  - `res_valid` <= 1, then go to RESP.
- RESP: `res_valid`, `res_data` and `status` stay stable until `res_valid & res_ready`. On that edge:
  - `res_valid` <= 0.
  - `retired` <= `retired` + 1, wrapping modulo 2^RETIRE_W.
  - Go to IDLE.
- `instr_valid` is ignored in EXEC and RESP, with no side effects.
- All register entries are writable, including r0. No register is hard-wired to zero.
- Writeback completes before the next instruction is accepted, so there are no read-after-write hazards.
- `alu_ina`, `alu_inb` and `alu_opcode` hold their last values between instructions.
- The sequencer does not interpret `op`; result semantics belong to the ALU. Opcodes 000/001 are add/subtract, and `alu_cout` is the raw adder carry, so subtract without borrow gives 1.
- Reset values: state=IDLE, all `regs`=0, `alu_ina`/`alu_inb`/`alu_opcode`=0, `res_valid`=0, `res_data`=0, `status`=0, `retired`=0. `instr_ready`=1 while in reset.
- Reset mid-operation, in EXEC or RESP: the instruction is discarded with no writeback and no `retired` increment. `res_valid` drops immediately, asynchronously.

## Timing
- Call the accept edge T0. ALU inputs are valid after T0.
- Writeback happens and `res_valid` rises at T0+1.
- Earliest response handshake is at T0+2, when `res_ready` is held high. `instr_ready` reasserts after that edge.
- Minimum issue interval is 3 cycles. Each cycle of `res_ready` low adds one cycle.
- `dbg_data` reflects a writeback in the cycle after the writeback edge.

## Test plan
- Reset: hold `rst_n` low for 3 cycles. All outputs match the reset values, `instr_ready`=1, and `dbg_data`=0 for every address.
- Load and add, with `res_ready`=1:
  - OR r1 <= r0|imm 0x55 and OR r2 <= r0|imm 0x1C.
  - ADD r3 <= r1+r2 gives `res_data`=0x71, status[2]=0.
  - SUB r3 <= r1-r2 gives 0x39, status[2]=1, status[1]=1.
  - `retired`=4; `dbg_data`@r3 = 0x39.
- Backpressure: issue XOR r1 ^ imm 0xFF, then hold `res_ready` low for 5 cycles. `res_valid`=1, `res_data`=0xAA and `instr_ready`=0 stay constant throughout. A driven `instr_valid` has no effect. Release gives one handshake and `retired` +1.
- Shift and zero:
  - Opcode 110 with ra=r1 (0x55) gives 0xAA.
  - Opcode 111 with imm 0x80 gives 0x00.
  - XOR ra=r0 (0) with imm 0x00 gives `res_data`=0x00 and status[0]=1.
- Reset mid-op: accept OR r1 <= r0|0x77, then pull `rst_n` low during EXEC. `res_valid` goes to 0 immediately, r1 reads 0 and `retired`=0 after release.
- Counter wrap: complete 256 instructions with RETIRE_W=8. `retired` reads 0xFF after 255 and 0x00 after 256.
